// File: rtl/jtag_chain_probe_pkg.sv
// Shared definitions for the JTAG chain probe.
// Holds the TAP state encodings reported by the external state tracker,
// the default expected IDCODE, and the probe FSM state type.
// The macros are kept for code that still expects the `STATE_* / `ID_CODE
// names. The enum and localparam mirror them so that RTL can import a package.

`ifndef JTAG_CHAIN_PROBE_DEFS
`define JTAG_CHAIN_PROBE_DEFS
`define STATE_TLR      4'h0
`define STATE_RTI      4'h1
`define STATE_SEL_DR   4'h2
`define STATE_CAP_DR   4'h3
`define STATE_SHIFT_DR 4'h4
`define STATE_EXIT1_DR 4'h5
`define STATE_PAUSE_DR 4'h6
`define STATE_EXIT2_DR 4'h7
`define STATE_UPD_DR   4'h8
`define STATE_SEL_IR   4'h9
`define STATE_CAP_IR   4'hA
`define STATE_SHIFT_IR 4'hB
`define STATE_EXIT1_IR 4'hC
`define STATE_PAUSE_IR 4'hD
`define STATE_EXIT2_IR 4'hE
`define STATE_UPD_IR   4'hF
`define ID_CODE        32'h4BA0_0477
`endif

package jtag_chain_probe_pkg;

   typedef enum logic [3:0] {
      TAP_TLR      = `STATE_TLR,
      TAP_RTI      = `STATE_RTI,
      TAP_SEL_DR   = `STATE_SEL_DR,
      TAP_CAP_DR   = `STATE_CAP_DR,
      TAP_SHIFT_DR = `STATE_SHIFT_DR,
      TAP_EXIT1_DR = `STATE_EXIT1_DR,
      TAP_PAUSE_DR = `STATE_PAUSE_DR,
      TAP_EXIT2_DR = `STATE_EXIT2_DR,
      TAP_UPD_DR   = `STATE_UPD_DR,
      TAP_SEL_IR   = `STATE_SEL_IR,
      TAP_CAP_IR   = `STATE_CAP_IR,
      TAP_SHIFT_IR = `STATE_SHIFT_IR,
      TAP_EXIT1_IR = `STATE_EXIT1_IR,
      TAP_PAUSE_IR = `STATE_PAUSE_IR,
      TAP_EXIT2_IR = `STATE_EXIT2_IR,
      TAP_UPD_IR   = `STATE_UPD_IR
   } tap_state_t;

   localparam logic [31:0] ID_CODE = `ID_CODE;

   typedef enum logic [2:0] {
      PS_IDLE,
      PS_WAIT_TLR,
      PS_ARM,
      PS_SHIFT,
      PS_EXIT,
      PS_EVAL,
      PS_ABORT
   } probe_state_t;

endpackage

// File: rtl/jtag_chain_probe_checker.sv
// Combinational IDCODE compare for one chain position.
// Ports:
//   word  - one DR_LEN-bit word captured from the chain
//   match - 1 when every bit selected by ID_MASK equals EXP_ID

module jtag_idcode_word_checker
   import jtag_chain_probe_pkg::*;
#(
   parameter int unsigned         DR_LEN  = 32,
   parameter logic [DR_LEN-1:0]   EXP_ID  = DR_LEN'(ID_CODE),
   parameter logic [DR_LEN-1:0]   ID_MASK = {DR_LEN{1'b1}}
) (
   input  logic [DR_LEN-1:0] word,
   output logic              match
);

   assign match = (((word ^ EXP_ID) & ID_MASK) == '0);

endmodule

// File: rtl/jtag_chain_probe.sv
// JTAG daisy-chain IDCODE probe.
// Walks the TAP from Test-Logic-Reset into Shift-DR, shifts MAX_DEV*DR_LEN
// bits out of the chain in one scan, returns to Test-Logic-Reset and
// reports which positions carried the expected IDCODE.
// Ports:
//   tck, rst_n        - JTAG clock, async active-low reset
//   start             - probe request (sampled on posedge tck)
//   tdo, tap_state    - chain output and TAP state from the tracker
//   tms, tdi          - JTAG drive, updated on negedge tck
//   busy, done        - probe in progress / one-tck result strobe
//   p_f, dev_count    - per-position match and leading match count
//   chain_open        - first word was stuck all-ones or all-zeros
//
// state       | meaning
// ------------+----------------------------------------------------------
// PS_IDLE     | no probe; tms=1 keeps the TAP parked in TLR
// PS_WAIT_TLR | probe requested outside TLR; tms=1 until TLR is reached
// PS_ARM      | tms 0,1,0,0 walks TLR->RTI->SelDR->Capture->Shift
// PS_SHIFT    | capture tdo each Shift-DR edge, tdi=1, tms=1 on last bit
// PS_EXIT     | tms=1 through Exit1->Update->SelDR->SelIR->TLR
// PS_EVAL     | first edge in TLR: register results, pulse done
// PS_ABORT    | tracker left the path: five tms=1 edges, then report open

module jtag_chain_probe
   import jtag_chain_probe_pkg::*;
#(
   parameter int unsigned       MAX_DEV = 4,
   parameter int unsigned       DR_LEN  = 32,
   parameter logic [DR_LEN-1:0] EXP_ID  = DR_LEN'(ID_CODE),
   parameter logic [DR_LEN-1:0] ID_MASK = {DR_LEN{1'b1}}
) (
   input  logic                         tck,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         tdo,
   input  logic [3:0]                   tap_state,
   output logic                         tms,
   output logic                         tdi,
   output logic                         busy,
   output logic                         done,
   output logic [MAX_DEV-1:0]           p_f,
   output logic [$clog2(MAX_DEV+1)-1:0] dev_count,
   output logic                         chain_open
);

   localparam int unsigned TOTAL = MAX_DEV * DR_LEN;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);
   localparam int unsigned DC_W  = $clog2(MAX_DEV + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(TOTAL);
   // Abort timer reloads to 4 and finishes on terminal count 0, so five
   // negedges with tms=1 are driven before done is raised.
   localparam logic [2:0]       ABORT_LAST = 3'd4;

   probe_state_t        state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [TOTAL-1:0]    bits_q, bits_d;
   logic [2:0]          abort_cnt_q, abort_cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [MAX_DEV-1:0]  p_f_q, p_f_d;
   logic [DC_W-1:0]     dev_count_q, dev_count_d;
   logic                chain_open_q, chain_open_d;
   logic                tms_q, tms_d;
   logic                tdi_q, tdi_d;

   logic [MAX_DEV-1:0]  match_w;
   logic [DR_LEN-1:0]   word0_w;
   logic                chain_open_w;
   logic [DC_W-1:0]     first_fail_w;

   for (genvar k = 0; k < MAX_DEV; k++) begin : g_chk
      jtag_idcode_word_checker #(
         .DR_LEN  (DR_LEN),
         .EXP_ID  (EXP_ID),
         .ID_MASK (ID_MASK)
      ) u_chk (
         .word  (bits_q[k*DR_LEN +: DR_LEN]),
         .match (match_w[k])
      );
   end

   assign word0_w      = bits_q[DR_LEN-1:0];
   assign chain_open_w = (&word0_w) || (~|word0_w);

   always_comb begin
      logic found;
      found        = 1'b0;
      first_fail_w = DC_W'(MAX_DEV);
      for (int k = 0; k < MAX_DEV; k++) begin
         if (!found && !match_w[k]) begin
            first_fail_w = DC_W'(k);
            found        = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      bits_d       = bits_q;
      abort_cnt_d  = abort_cnt_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      p_f_d        = p_f_q;
      dev_count_d  = dev_count_q;
      chain_open_d = chain_open_q;

      case (state_q)
         PS_IDLE: begin
            // done_q high means this is the cycle right after a result
            // strobe; a start here belongs to the finished probe.
            if (start && !done_q) begin
               busy_d = 1'b1;
               if (tap_state == TAP_TLR) state_d = PS_ARM;
               else                      state_d = PS_WAIT_TLR;
            end
         end

         PS_WAIT_TLR: begin
            if (tap_state == TAP_TLR) state_d = PS_ARM;
         end

         PS_ARM: begin
            bit_cnt_d = '0;
            case (tap_state)
               TAP_TLR, TAP_RTI, TAP_SEL_DR: ;
               TAP_CAP_DR: state_d = PS_SHIFT;
               default: begin
                  state_d     = PS_ABORT;
                  abort_cnt_d = ABORT_LAST;
               end
            endcase
         end

         PS_SHIFT: begin
            if (tap_state == TAP_SHIFT_DR) begin
               for (int i = 0; i < TOTAL; i++) begin
                  if (bit_cnt_q == CNT_W'(i)) bits_d[i] = tdo;
               end
               if (bit_cnt_q != FULL_CNT) bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) state_d = PS_EXIT;
            end else begin
               state_d     = PS_ABORT;
               abort_cnt_d = ABORT_LAST;
            end
         end

         PS_EXIT: begin
            case (tap_state)
               TAP_EXIT1_DR, TAP_UPD_DR, TAP_SEL_DR: ;
               TAP_SEL_IR: state_d = PS_EVAL;
               default: begin
                  state_d     = PS_ABORT;
                  abort_cnt_d = ABORT_LAST;
               end
            endcase
         end

         PS_EVAL: begin
            if (tap_state == TAP_TLR) begin
               p_f_d        = chain_open_w ? '0 : match_w;
               dev_count_d  = chain_open_w ? '0 : first_fail_w;
               chain_open_d = chain_open_w;
               done_d       = 1'b1;
               busy_d       = 1'b0;
               state_d      = PS_IDLE;
            end else begin
               state_d     = PS_ABORT;
               abort_cnt_d = ABORT_LAST;
            end
         end

         PS_ABORT: begin
            if (abort_cnt_q == '0) begin
               p_f_d        = '0;
               dev_count_d  = '0;
               chain_open_d = 1'b1;
               done_d       = 1'b1;
               busy_d       = 1'b0;
               state_d      = PS_IDLE;
            end else begin
               abort_cnt_d = abort_cnt_q - 1'b1;
            end
         end

         default: state_d = PS_IDLE;
      endcase
   end

   // TMS/TDI are picked on the falling edge from the tracker's view so the
   // TAP sees a stable value on the next rising edge.
   always_comb begin
      tms_d = 1'b1;
      tdi_d = 1'b0;
      case (state_q)
         PS_ARM:   tms_d = (tap_state == TAP_RTI);
         PS_SHIFT: begin
            tms_d = (bit_cnt_q == LAST_BIT);
            tdi_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= PS_IDLE;
         bit_cnt_q    <= '0;
         bits_q       <= '0;
         abort_cnt_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         p_f_q        <= '0;
         dev_count_q  <= '0;
         chain_open_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         bits_q       <= bits_d;
         abort_cnt_q  <= abort_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         p_f_q        <= p_f_d;
         dev_count_q  <= dev_count_d;
         chain_open_q <= chain_open_d;
      end
   end

   always_ff @(negedge tck or negedge rst_n) begin
      if (!rst_n) begin
         tms_q <= 1'b1;
         tdi_q <= 1'b0;
      end else begin
         tms_q <= tms_d;
         tdi_q <= tdi_d;
      end
   end

   assign tms        = tms_q;
   assign tdi        = tdi_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign p_f        = p_f_q;
   assign dev_count  = dev_count_q;
   assign chain_open = chain_open_q;

endmodule

// File: tb/tb_jtag_chain_probe.sv
// Bench for jtag_chain_probe: a behavioural TAP tracker and a bit-queue
// model of the daisy chain drive the probe; expected results come from the
// IDCODE words the chain model was loaded with.

module tb_jtag_chain_probe;
   import jtag_chain_probe_pkg::*;

   localparam int          MAX_DEV = 4;
   localparam int          DR_LEN  = 32;
   localparam int          TOTAL   = MAX_DEV * DR_LEN;
   localparam logic [31:0] EXP     = ID_CODE;
   localparam logic [31:0] MASK_A  = 32'hFFFF_FFFF;
   localparam logic [31:0] MASK_B  = 32'h0FFF_FFFF;

   logic       tck = 1'b0;
   logic       rst_n;
   logic       start;
   logic       tdo = 1'b0;
   logic [3:0] tap_state = TAP_TLR;

   logic       tms, tdi, busy, done, chain_open;
   logic [3:0] p_f;
   logic [2:0] dev_count;
   logic       tms_b, tdi_b, busy_b, done_b, chain_open_b;
   logic [3:0] p_f_b;
   logic [2:0] dev_count_b;

   int          total = 0;
   int          bad   = 0;
   int          npop;
   logic [31:0] dev_id [4];
   bit          stuck0;
   bit          jolt;
   logic [3:0]  jolt_val;
   int          shift_seen = 0;
   int          done_seen  = 0;
   bit          q [$];

   jtag_chain_probe #(.MAX_DEV(MAX_DEV), .DR_LEN(DR_LEN), .EXP_ID(EXP), .ID_MASK(MASK_A)) dut (
      .tck(tck), .rst_n(rst_n), .start(start), .tdo(tdo), .tap_state(tap_state),
      .tms(tms), .tdi(tdi), .busy(busy), .done(done), .p_f(p_f),
      .dev_count(dev_count), .chain_open(chain_open));

   // Same inputs, relaxed mask: ignores the version nibble.
   jtag_chain_probe #(.MAX_DEV(MAX_DEV), .DR_LEN(DR_LEN), .EXP_ID(EXP), .ID_MASK(MASK_B)) dut_b (
      .tck(tck), .rst_n(rst_n), .start(start), .tdo(tdo), .tap_state(tap_state),
      .tms(tms_b), .tdi(tdi_b), .busy(busy_b), .done(done_b), .p_f(p_f_b),
      .dev_count(dev_count_b), .chain_open(chain_open_b));

   always #5 tck = ~tck;

   function automatic logic [3:0] next_tap(input logic [3:0] s, input logic m);
      case (s)
         TAP_TLR:      return m ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      return m ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   return m ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_CAP_DR:   return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR: return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR: return m ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_PAUSE_DR: return m ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR: return m ? TAP_UPD_DR   : TAP_SHIFT_DR;
         TAP_UPD_DR:   return m ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:   return m ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_IR:   return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR: return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR: return m ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_IR: return m ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR: return m ? TAP_UPD_IR   : TAP_SHIFT_IR;
         default:      return m ? TAP_SEL_DR   : TAP_RTI;
      endcase
   endfunction

   // TAP tracker plus chain model: Capture-DR loads the populated devices'
   // IDCODEs (device 0 nearest TDO, LSB first), Shift-DR feeds tdi in.
   always @(posedge tck) begin
      tap_state <= jolt ? jolt_val : next_tap(tap_state, tms);
      if (tap_state == TAP_SHIFT_DR) shift_seen <= shift_seen + 1;
      if (done) done_seen <= done_seen + 1;
      if (tap_state == TAP_CAP_DR) begin
         q.delete();
         for (int k = 0; k < npop; k++)
            for (int b = 0; b < DR_LEN; b++) q.push_back(dev_id[k][b]);
      end else if (tap_state == TAP_SHIFT_DR) begin
         q.push_back(tdi);
         void'(q.pop_front());
      end
   end

   always @(negedge tck) tdo <= stuck0 ? 1'b0 : ((q.size() > 0) ? q[0] : tdi);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Expected results from the words the chain will present.
   function automatic void model(input logic [31:0] mask, output logic [3:0] epf,
                                 output logic [2:0] edc, output logic eco);
      logic [31:0] w;
      int n;
      epf = '0;
      eco = 1'b0;
      for (int k = 0; k < MAX_DEV; k++) begin
         w = stuck0 ? 32'h0 : ((k < npop) ? dev_id[k] : 32'hFFFF_FFFF);
         if (k == 0) eco = (w == 32'hFFFF_FFFF) || (w == 32'h0);
         epf[k] = (((w ^ EXP) & mask) == 32'h0);
      end
      if (eco) epf = '0;
      n = 0;
      while (n < MAX_DEV && epf[n]) n++;
      edc = 3'(n);
   endfunction

   task automatic wait_done(output int c);
      c = 0;
      while (!done && c < 1000) begin
         @(negedge tck);
         c++;
      end
   endtask

   task automatic check_results(input string tag);
      logic [3:0] epf_a, epf_b;
      logic [2:0] edc_a, edc_b;
      logic       eco_a, eco_b;
      model(MASK_A, epf_a, edc_a, eco_a);
      model(MASK_B, epf_b, edc_b, eco_b);
      chk({tag, "_pf"},      p_f,          epf_a);
      chk({tag, "_dc"},      dev_count,    edc_a);
      chk({tag, "_open"},    chain_open,   eco_a);
      chk({tag, "_pf_b"},    p_f_b,        epf_b);
      chk({tag, "_dc_b"},    dev_count_b,  edc_b);
      chk({tag, "_open_b"},  chain_open_b, eco_b);
      chk({tag, "_tap_tlr"}, tap_state,    TAP_TLR);
      chk({tag, "_busy"},    busy,         1'b0);
   endtask

   task automatic probe(input string tag, input bit start_on_done);
      int s0, d0, c;
      s0 = shift_seen;
      d0 = done_seen;
      start = 1'b1;
      @(negedge tck);
      start = 1'b0;
      wait_done(c);
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_done_b"}, done_b, 1'b1);
      chk({tag, "_shifts"}, 32'(shift_seen - s0), TOTAL);
      check_results(tag);
      if (start_on_done) start = 1'b1;
      @(negedge tck);
      start = 1'b0;
      chk({tag, "_done_low"}, done, 1'b0);
      chk({tag, "_done_cnt"}, 32'(done_seen - d0), 1);
      if (start_on_done) chk({tag, "_start_on_done_ignored"}, busy, 1'b0);
      repeat (2) @(negedge tck);
   endtask

   initial begin
      int s0, d0, c;
      rst_n    = 1'b0;
      start    = 1'b0;
      npop     = 4;
      stuck0   = 1'b0;
      jolt     = 1'b0;
      jolt_val = TAP_TLR;
      for (int k = 0; k < 4; k++) dev_id[k] = EXP;

      repeat (3) @(negedge tck);
      chk("rst_tms", tms, 1'b1);
      chk("rst_tdi", tdi, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pf", p_f, 4'h0);
      chk("rst_dc", dev_count, 3'd0);
      chk("rst_open", chain_open, 1'b0);
      chk("rst_b_tms", tms_b, 1'b1);
      chk("rst_b_tdi", tdi_b, 1'b0);
      chk("rst_b_busy", busy_b, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge tck);

      probe("all4", 1'b0);
      npop = 2;
      probe("two", 1'b0);
      npop = 4;
      stuck0 = 1'b1;
      probe("stuck0", 1'b1);
      stuck0 = 1'b0;
      dev_id[1] = EXP ^ 32'h3000_0000;
      probe("version", 1'b0);
      dev_id[1] = EXP;

      // Start from RTI, then a second start while busy.
      jolt = 1'b1;
      jolt_val = TAP_RTI;
      @(negedge tck);
      jolt = 1'b0;
      chk("rti_tap", tap_state, TAP_RTI);
      s0 = shift_seen;
      d0 = done_seen;
      start = 1'b1;
      @(negedge tck);
      start = 1'b0;
      chk("rti_busy", busy, 1'b1);
      repeat (10) @(negedge tck);
      start = 1'b1;
      @(negedge tck);
      start = 1'b0;
      wait_done(c);
      chk("rti_done", done, 1'b1);
      check_results("rti");
      repeat (300) @(negedge tck);
      chk("rti_done_cnt", 32'(done_seen - d0), 1);
      chk("rti_shifts", 32'(shift_seen - s0), TOTAL);

      // Tracker resync mid-shift: abort after five tms=1 edges.
      s0 = shift_seen;
      start = 1'b1;
      @(negedge tck);
      start = 1'b0;
      c = 0;
      while ((shift_seen - s0) < 20 && c < 500) begin
         @(negedge tck);
         c++;
      end
      jolt = 1'b1;
      jolt_val = TAP_PAUSE_DR;
      @(negedge tck);
      jolt = 1'b0;
      wait_done(c);
      chk("abort_done", done, 1'b1);
      chk("abort_latency", c, 6);
      chk("abort_pf", p_f, 4'h0);
      chk("abort_dc", dev_count, 3'd0);
      chk("abort_open", chain_open, 1'b1);
      chk("abort_tap", tap_state, TAP_TLR);
      @(negedge tck);
      chk("abort_done_low", done, 1'b0);
      repeat (2) @(negedge tck);

      // Reset at shift bit 50 after a good probe.
      probe("pre_rst", 1'b0);
      s0 = shift_seen;
      start = 1'b1;
      @(negedge tck);
      start = 1'b0;
      c = 0;
      while ((shift_seen - s0) < 50 && c < 500) begin
         @(negedge tck);
         c++;
      end
      chk("midrst_reached_bit50", 32'(shift_seen - s0), 50);
      rst_n = 1'b0;
      #1;
      chk("midrst_tms", tms, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_pf", p_f, 4'h0);
      chk("midrst_dc", dev_count, 3'd0);
      chk("midrst_open", chain_open, 1'b0);
      chk("midrst_done", done, 1'b0);
      repeat (3) @(negedge tck);
      rst_n = 1'b1;
      d0 = done_seen;
      repeat (200) @(negedge tck);
      chk("midrst_no_done", 32'(done_seen - d0), 0);
      chk("midrst_tap_tlr", tap_state, TAP_TLR);
      probe("post_rst", 1'b0);

      // Randomised chains.
      for (int r = 0; r < 8; r++) begin
         npop   = int'($urandom_range(1, 4));
         stuck0 = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
               0, 1:    dev_id[k] = EXP;
               2:       dev_id[k] = EXP ^ (32'($urandom_range(1, 15)) << 28);
               default: dev_id[k] = $urandom;
            endcase
         end
         probe($sformatf("rnd%0d", r), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
